// File: rtl/alu_wb_stage_if.sv
// Handshake bundle between the adder, the ALU writeback stage and the register file.
// The stage uses the slave modport; the upstream/regfile side uses master.
interface alu_wb_stage_if #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_a_msb;
  logic             in_b_msb;
  logic [RD_W-1:0]  in_rd;
  logic             in_we;

  logic             wb_valid;
  logic             wb_ready;
  logic [WIDTH-1:0] wb_data;
  logic [RD_W-1:0]  wb_rd;
  logic             wb_we;
  logic [3:0]       wb_flags;
  logic [3:0]       psw;
  logic [1:0]       count;

  modport slave (
    input  in_valid, in_sum, in_cout, in_a_msb, in_b_msb, in_rd, in_we, wb_ready,
    output in_ready, wb_valid, wb_data, wb_rd, wb_we, wb_flags, psw, count
  );

  modport master (
    output in_valid, in_sum, in_cout, in_a_msb, in_b_msb, in_rd, in_we, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_rd, wb_we, wb_flags, psw, count
  );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry FIFO of {sum, rd, we, flags} feeding the regfile, plus PSW.
// Define WB_OVERFLOW_FLAG_EN to compute the V flag; otherwise V is tied to 0.
module alu_wb_stage #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 5
) (
  input logic           clk,
  input logic           rst,
  alu_wb_stage_if.slave bus
);

  logic [1:0][WIDTH-1:0] data_q, data_d;
  logic [1:0][RD_W-1:0]  rd_q,   rd_d;
  logic [1:0]            we_q,   we_d;
  logic [1:0][3:0]       flg_q,  flg_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q,  count_d;
  logic [3:0]            psw_q,    psw_d;

  logic       in_ready;
  logic       wb_valid;
  logic       push, pop;
  logic       z_flag, n_flag, v_flag;
  logic [3:0] in_flags;

  // rst is folded in so the upstream never sees ready while the stage is held in reset
  assign in_ready = (count_q != 2'd2) && rst;
  assign wb_valid = (count_q != 2'd0);
  assign push     = bus.in_valid && in_ready;
  assign pop      = wb_valid && bus.wb_ready;

  assign z_flag = (bus.in_sum == '0);
  assign n_flag = bus.in_sum[WIDTH-1];
`ifdef WB_OVERFLOW_FLAG_EN
  assign v_flag = (bus.in_a_msb == bus.in_b_msb) && (bus.in_sum[WIDTH-1] != bus.in_a_msb);
`else
  logic unused_msbs;
  assign unused_msbs = bus.in_a_msb ^ bus.in_b_msb;
  assign v_flag      = 1'b0;
`endif
  assign in_flags = {z_flag, bus.in_cout, n_flag, v_flag};

  always_comb begin
    data_d   = data_q;
    rd_d     = rd_q;
    we_d     = we_q;
    flg_d    = flg_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    psw_d    = psw_q;
    if (push) begin
      data_d[wr_ptr_q] = bus.in_sum;
      rd_d[wr_ptr_q]   = bus.in_rd;
      we_d[wr_ptr_q]   = bus.in_we;
      flg_d[wr_ptr_q]  = in_flags;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      psw_d    = flg_q[rd_ptr_q];
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      rd_q     <= '0;
      we_q     <= '0;
      flg_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      psw_q    <= 4'd0;
    end else begin
      data_q   <= data_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      flg_q    <= flg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      psw_q    <= psw_d;
    end
  end

  // Popped slots keep stale contents, so the head view is masked when empty
  assign bus.in_ready = in_ready;
  assign bus.wb_valid = wb_valid;
  assign bus.wb_data  = wb_valid ? data_q[rd_ptr_q] : '0;
  assign bus.wb_rd    = wb_valid ? rd_q[rd_ptr_q]   : '0;
  assign bus.wb_we    = wb_valid && we_q[rd_ptr_q];
  assign bus.wb_flags = wb_valid ? flg_q[rd_ptr_q]  : 4'd0;
  assign bus.psw      = psw_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: FIFO ordering, flags, PSW commit and async reset.
module tb_alu_wb_stage;
  localparam int WIDTH = 16;
  localparam int RD_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_wb_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

  alu_wb_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef WB_OVERFLOW_FLAG_EN
  localparam logic [3:0] OVF_FLAGS = 4'b0011;
`else
  localparam logic [3:0] OVF_FLAGS = 4'b0010;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] sum, input logic cout,
                       input logic [4:0] rd, input logic we);
    bus.in_valid = v;
    bus.in_sum   = sum;
    bus.in_cout  = cout;
    bus.in_rd    = rd;
    bus.in_we    = we;
  endtask

  initial begin
    bus.in_a_msb = 1'b0;
    bus.in_b_msb = 1'b0;
    bus.wb_ready = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0);

    // Reset state
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_psw",      32'(bus.psw),      32'd0);
    chk("rst_wb_we",    32'(bus.wb_we),    32'd0);
    #10 rst = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Zero sum with carry, popped the cycle after it lands
    drive(1'b1, 16'h0000, 1'b1, 5'd3, 1'b1);
    bus.wb_ready = 1'b1;
    step();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("z_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("z_flags",    32'(bus.wb_flags), 32'hC);
    chk("z_rd",       32'(bus.wb_rd),    32'd3);
    chk("z_we",       32'(bus.wb_we),    32'd1);
    step();
    chk("z_psw",   32'(bus.psw),      32'hC);
    chk("z_count", 32'(bus.count),    32'd0);
    chk("z_empty", 32'(bus.wb_valid), 32'd0);

    // Fill to two with regfile stalled; third offer refused
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h0001, 1'b0, 5'd1, 1'b1);
    step();
    drive(1'b1, 16'h0002, 1'b1, 5'd2, 1'b1);
    step();
    chk("full_count",    32'(bus.count),    32'd2);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 16'h0003, 1'b0, 5'd3, 1'b1);
    step();
    chk("full_hold_count", 32'(bus.count),   32'd2);
    chk("full_head0",      32'(bus.wb_data), 32'h1);
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0);
    bus.wb_ready = 1'b1;
    step();
    chk("full_head1",   32'(bus.wb_data),  32'h2);
    chk("full_count1",  32'(bus.count),    32'd1);
    chk("full_ready1",  32'(bus.in_ready), 32'd1);
    chk("full_psw1",    32'(bus.psw),      32'h0);
    step();
    chk("drain_count",  32'(bus.count),    32'd0);
    chk("drain_psw",    32'(bus.psw),      32'h4);
    chk("drain_data0",  32'(bus.wb_data),  32'h0);
    chk("drain_flags0", 32'(bus.wb_flags), 32'h0);

    // Simultaneous push and pop at occupancy one
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h00AA, 1'b0, 5'd4, 1'b1);
    step();
    drive(1'b1, 16'h00BB, 1'b0, 5'd5, 1'b1);
    bus.wb_ready = 1'b1;
    step();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("pp_count", 32'(bus.count),   32'd1);
    chk("pp_data",  32'(bus.wb_data), 32'hBB);
    chk("pp_rd",    32'(bus.wb_rd),   32'd5);
    step();
    chk("pp_drain", 32'(bus.count),   32'd0);

    // Signed overflow candidate
    bus.wb_ready = 1'b0;
    bus.in_a_msb = 1'b0;
    bus.in_b_msb = 1'b0;
    drive(1'b1, 16'h8000, 1'b0, 5'd6, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("ovf_flags", 32'(bus.wb_flags), 32'(OVF_FLAGS));
    bus.wb_ready = 1'b1;
    step();
    chk("ovf_psw", 32'(bus.psw), 32'(OVF_FLAGS));

    // Entry without register write still commits flags
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'hFFFF, 1'b1, 5'd7, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("nowe_we",    32'(bus.wb_we),    32'd0);
    chk("nowe_valid", 32'(bus.wb_valid), 32'd1);
    chk("nowe_flags", 32'(bus.wb_flags), 32'h6);
    bus.wb_ready = 1'b1;
    step();
    chk("nowe_psw", 32'(bus.psw), 32'h6);

    // wb_ready while empty changes nothing
    step();
    step();
    chk("idle_psw",   32'(bus.psw),   32'h6);
    chk("idle_count", 32'(bus.count), 32'd0);

    // Async reset while full, then first push right after release
    bus.wb_ready = 1'b0;
    drive(1'b1, 16'h0011, 1'b0, 5'd1, 1'b1);
    step();
    drive(1'b1, 16'h0022, 1'b0, 5'd2, 1'b1);
    step();
    chk("pre_rst_count", 32'(bus.count), 32'd2);
    drive(1'b1, 16'h0055, 1'b0, 5'd9, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("arst_count",    32'(bus.count),    32'd0);
    chk("arst_valid",    32'(bus.wb_valid), 32'd0);
    chk("arst_psw",      32'(bus.psw),      32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_data",     32'(bus.wb_data),  32'd0);
    #2 rst = 1'b1;
    step();
    drive(1'b0, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("post_rst_count", 32'(bus.count),   32'd1);
    chk("post_rst_data",  32'(bus.wb_data), 32'h55);
    chk("post_rst_rd",    32'(bus.wb_rd),   32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter: WIDTH, 16, datapath width of adder result; legal range 4..32.
REQ-002 Parameter: RD_W, 5, destination register index width.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  upstream adder result valid.
REQ-006 Port: in_ready  output  1  stage can accept; high iff occupancy < 2 and rst high.
REQ-007 Port: in_sum  input  WIDTH  adder sum.
REQ-008 Port: in_cout  input  1  adder carry-out.
REQ-009 Port: in_a_msb, in_b_msb  input  1 each  operand sign bits, for overflow.
REQ-010 Port: in_rd  input  RD_W  destination register index.
REQ-011 Port: in_we  input  1  register-file write requested.
REQ-012 Port: wb_valid  output  1  head entry presented to register-file write port.
REQ-013 Port: wb_ready  input  1  register file accepts head entry.
REQ-014 Port: wb_data  output  WIDTH  head sum.
REQ-015 Port: wb_rd  output  RD_W  head destination index.
REQ-016 Port: wb_we  output  1  head write enable, gated by wb_valid.
REQ-017 Port: wb_flags  output  4  head flags {Z,C,N,V}.
REQ-018 Port: psw  output  4  committed status word {Z,C,N,V}.
REQ-019 Port: count  output  2  occupancy 0..2.

Function
REQ-020 Stage SHALL be a 2-entry FIFO (write ptr, read ptr, 1-bit each, wrap 1->0) plus psw register.
REQ-021 Push SHALL occur on edge when in_valid && in_ready; pop on edge when wb_valid && wb_ready.
REQ-022 Flags SHALL be computed at push: Z = (in_sum==0), C = in_cout, N = in_sum[WIDTH-1], V per REQ-034.
REQ-023 Latency: entry pushed at edge k SHALL appear on wb_* with wb_valid high after edge k when the FIFO was empty.
REQ-024 wb_valid SHALL equal (count != 0); wb_* SHALL reflect head entry combinationally from storage.
REQ-025 When count==0, wb_data, wb_rd, wb_flags SHALL be 0 and wb_we SHALL be 0.
REQ-026 Simultaneous push and pop with count==1: count stays 1, new entry becomes head after edge.
REQ-027 Count==2: in_ready low, in_valid ignored; pop SHALL bring count to 1 and raise in_ready next cycle.
REQ-028 Count==0: wb_ready ignored; no pointer or psw change.
REQ-029 psw SHALL load the popped entry's flags on each pop edge, otherwise hold.
REQ-030 Entries with in_we==0 SHALL still traverse the FIFO and update psw on pop; wb_we low for them.
REQ-031 Storage contents SHALL not change when no push occurs; upstream data need not be held after push.

Reset
REQ-032 rst low SHALL asynchronously clear pointers, count, psw, and all storage to 0; in_ready, wb_valid, wb_we low while rst low.
REQ-033 Reset mid-transfer SHALL discard all entries; first push allowed on first rising edge with rst high.

Configuration
REQ-034 Macro WB_OVERFLOW_FLAG_EN: defined -> V = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb); undefined -> V tied 0, in_a_msb/in_b_msb unused, V bit of wb_flags/psw always 0.

Verification
REQ-035 Reset then push sum=16'h0000, cout=1, rd=3, we=1, wb_ready=1 -> next cycle wb_valid=1, wb_flags=4'b1100, after pop psw=4'b1100, count=0.
REQ-036 wb_ready=0, push 16'h0001, 16'h0002, 16'h0003 back-to-back -> count=2, in_ready=0, third not accepted; then wb_ready=1 -> wb_data 16'h0001 then 16'h0002.
REQ-037 count=1 (head 16'h00AA), simultaneous push 16'h00BB and pop -> count stays 1, wb_data=16'h00BB next cycle.
REQ-038 With WB_OVERFLOW_FLAG_EN: push sum=16'h8000, a_msb=0, b_msb=0 -> wb_flags=4'b0011; without macro -> 4'b0010.
REQ-039 count=2, assert rst low mid-cycle -> count=0, wb_valid=0, psw=0 immediately, no clock edge required.
REQ-040 Push we=0, sum=16'hFFFF -> wb_we=0, wb_valid=1, after pop psw N=1.
